// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, phase encoding and phase decode helper.
package vga_timing_pkg;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned CNT_MAX = 2047;
    localparam int unsigned FCNT_W  = 8;

    // Default 640x480@60 timing
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;

    localparam int unsigned DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int unsigned DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int unsigned DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_t;

    // Phase of a counter position within one axis period
    function automatic phase_t axis_phase(
        input logic [CNT_W-1:0] pos,
        input int unsigned      sync_len,
        input int unsigned      back_len,
        input int unsigned      active_len
    );
        int unsigned p;
        p = 32'(pos);
        if (p < sync_len) return PH_SYNC;
        if (p < sync_len + back_len) return PH_BACK;
        if (p < sync_len + back_len + active_len) return PH_ACTIVE;
        return PH_FRONT;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with phase decode of its next value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK,
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output phase_t           phase_c,
    output logic             wrap_c,
    output logic             in_active_c,
    output logic [CNT_W-1:0] offset_c
);

    localparam int unsigned TOTAL     = SYNC + BACK + ACTIVE + FRONT;
    localparam int unsigned ACT_START = SYNC + BACK;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Next position and its decode; the top registers these so outputs track the counter edge
    always_comb begin
        wrap_c     = step && (count == CNT_W'(TOTAL - 1));
        count_next = count;
        if (step) begin
            count_next = wrap_c ? '0 : count + CNT_W'(1);
        end
        phase_c     = axis_phase(count_next, SYNC, BACK, ACTIVE);
        in_active_c = (phase_c == PH_ACTIVE);
        offset_c    = in_active_c ? count_next - CNT_W'(ACT_START) : '0;
    end

    // Position register; reset parks on the last position so the first step wraps to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CNT_W'(TOTAL - 1);
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync_module.sv
// Raster timing generator: pixel divider, h/v axis counters, registered sync/address outputs.
module vga_sync_module
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [CNT_W-1:0]  col_addr_sig,
    output logic [CNT_W-1:0]  row_addr_sig,
    output logic              ready_sig,
    output logic              hsync,
    output logic              vsync,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("CLK_DIV must be at least 1");
    end
    if (H_TOTAL > CNT_MAX) begin : g_bad_h_total
        $error("H_TOTAL does not fit the 11-bit horizontal counter");
    end
    if (V_TOTAL > CNT_MAX) begin : g_bad_v_total
        $error("V_TOTAL does not fit the 11-bit vertical counter");
    end

    logic [DIV_W-1:0] div;
    logic             pix_en_c;
    phase_t           h_phase_c;
    phase_t           v_phase_c;
    logic             h_wrap_c;
    logic             v_wrap_c;
    logic             h_act_c;
    logic             v_act_c;
    logic [CNT_W-1:0] h_off_c;
    logic [CNT_W-1:0] v_off_c;
    logic             ready_c;
    logic             frame_start_c;

    assign pix_en_c = (div == DIV_W'(CLK_DIV - 1));

    // Pixel-rate divider; with CLK_DIV=1 div stays 0 and pix_en is always high
    always_ff @(posedge clk) begin
        if (rst || pix_en_c) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT)
    ) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .step        (pix_en_c),
        .phase_c     (h_phase_c),
        .wrap_c      (h_wrap_c),
        .in_active_c (h_act_c),
        .offset_c    (h_off_c)
    );

    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT)
    ) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .step        (h_wrap_c),
        .phase_c     (v_phase_c),
        .wrap_c      (v_wrap_c),
        .in_active_c (v_act_c),
        .offset_c    (v_off_c)
    );

    assign ready_c       = h_act_c && v_act_c;
    assign frame_start_c = h_wrap_c && v_wrap_c;

    // Registered outputs from next counter values; pulses last one clk since wraps need pix_en
    always_ff @(posedge clk) begin
        if (rst) begin
            col_addr_sig <= '0;
            row_addr_sig <= '0;
            ready_sig    <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            col_addr_sig <= ready_c ? h_off_c : '0;
            row_addr_sig <= ready_c ? v_off_c : '0;
            ready_sig    <= ready_c;
            hsync        <= (h_phase_c == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync        <= (v_phase_c == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            line_start   <= h_wrap_c;
            frame_start  <= frame_start_c;
            if (frame_start_c) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_module.sv
// Bench: three generator configurations checked each clk against an arithmetic raster model.
module tb_vga_sync_module;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Config D: default timing. Config A: small timing, CLK_DIV=2. Config B: tiny timing, CLK_DIV=1, active-high sync.
    logic [10:0] d_col, d_row, a_col, a_row, b_col, b_row;
    logic        d_ready, d_hs, d_vs, d_ls, d_fs;
    logic        a_ready, a_hs, a_vs, a_ls, a_fs;
    logic        b_ready, b_hs, b_vs, b_ls, b_fs;
    logic [7:0]  d_fc, a_fc, b_fc;

    vga_sync_module u_def (
        .clk(clk), .rst(rst), .col_addr_sig(d_col), .row_addr_sig(d_row), .ready_sig(d_ready),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_sync_module #(
        .CLK_DIV(2), .H_SYNC(8), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_FRONT(2), .SYNC_POL(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .col_addr_sig(a_col), .row_addr_sig(a_row), .ready_sig(a_ready),
        .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_sync_module #(
        .CLK_DIV(1), .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .col_addr_sig(b_col), .row_addr_sig(b_row), .ready_sig(b_ready),
        .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    logic [34:0]  obs_d, obs_a, obs_b;
    logic [104:0] obs_all;
    assign obs_d   = {d_col, d_row, d_ready, d_hs, d_vs, d_ls, d_fs, d_fc};
    assign obs_a   = {a_col, a_row, a_ready, a_hs, a_vs, a_ls, a_fs, a_fc};
    assign obs_b   = {b_col, b_row, b_ready, b_hs, b_vs, b_ls, b_fs, b_fc};
    assign obs_all = {obs_d, obs_a, obs_b};

    int unsigned k;          // rising edges since the last edge that sampled rst high
    int          vectors     = 0;
    int          miscompares = 0;

    // Expected outputs after kk edges out of reset: pixel n = kk/div, raster position = (n-1) mod frame
    function automatic logic [34:0] model(
        input int unsigned kk, input int unsigned dv,
        input int unsigned hs, input int unsigned hb, input int unsigned ha, input int unsigned hf,
        input int unsigned vs, input int unsigned vb, input int unsigned va, input int unsigned vf,
        input bit pol
    );
        int unsigned ht, vt, ft, n, q, h, v, col, row, fc;
        bit pe, rdy, hsy, vsy, ls, fs;
        ht = hs + hb + ha + hf;
        vt = vs + vb + va + vf;
        ft = ht * vt;
        n  = kk / dv;
        if (n == 0) return {11'd0, 11'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 8'd0};
        q   = (n - 1) % ft;
        h   = q % ht;
        v   = q / ht;
        pe  = (kk % dv) == 0;
        rdy = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
        col = rdy ? h - (hs + hb) : 0;
        row = rdy ? v - (vs + vb) : 0;
        hsy = (h < hs) ? pol : ~pol;
        vsy = (v < vs) ? pol : ~pol;
        ls  = pe && (h == 0);
        fs  = pe && (q == 0);
        fc  = ((n - 1) / ft + 1) % 256;
        return {11'(col), 11'(row), rdy, hsy, vsy, ls, fs, 8'(fc)};
    endfunction

    function automatic logic [104:0] expect_all(input int unsigned kk);
        return {model(kk, 2, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0),
                model(kk, 2, 8, 4, 16, 4, 2, 3, 6, 2, 1'b0),
                model(kk, 1, 4, 2, 8, 2, 1, 1, 4, 1, 1'b1)};
    endfunction

    // Advance one clk and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        if (rst) k = 0;
        else     k++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (obs_all !== expect_all(k)) begin
                miscompares++;
                $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs_all, expect_all(k));
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs_all !== expect_all(k)) begin
                miscompares++;
                $display("FAIL reset_release k=%0d got=%h exp=%h", k, obs_all, expect_all(k));
            end
        end
        vectors++;
        if ({d_fs, d_ls, d_fc, d_hs, d_vs, d_ready, d_col, d_row} !== {1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0}) begin
            miscompares++;
            $display("FAIL first_frame_start got fs=%b ls=%b fc=%0d hs=%b vs=%b rdy=%b exp fs=1 ls=1 fc=1 hs=0 vs=0 rdy=0",
                     d_fs, d_ls, d_fc, d_hs, d_vs, d_ready);
        end
    endtask

    task automatic test_line_timing();
        int  gap;
        int  hs_low;
        bit  done;
        gap    = 0;
        hs_low = (d_hs == 1'b0) ? 1 : 0;
        done   = 1'b0;
        for (int i = 0; i < 1700 && !done; i++) begin
            tick();
            vectors++;
            if (obs_all !== expect_all(k)) begin
                miscompares++;
                $display("FAIL line_run k=%0d got=%h exp=%h", k, obs_all, expect_all(k));
            end
            gap++;
            if (d_ls) done = 1'b1;
            else if (d_hs == 1'b0) hs_low++;
        end
        vectors++;
        if (gap != 1600) begin
            miscompares++;
            $display("FAIL line_period got=%0d clks exp=1600", gap);
        end
        vectors++;
        if (hs_low != 192) begin
            miscompares++;
            $display("FAIL hsync_width got=%0d clks exp=192", hs_low);
        end
    endtask

    task automatic test_frame_timing();
        int unsigned fs_k[$];
        int unsigned last_ls_k, first_rdy_k, max_col, max_row;
        int  vs_low, rdy_cnt, gate_err, pulse_err;
        bit  seen_rdy, prev_ls, prev_fs;
        logic [10:0] first_col, first_row;
        last_ls_k = 0; first_rdy_k = 0; max_col = 0; max_row = 0;
        vs_low = 0; rdy_cnt = 0; gate_err = 0; pulse_err = 0;
        seen_rdy = 1'b0; prev_ls = a_ls; prev_fs = a_fs;
        first_col = '1; first_row = '1;
        for (int i = 0; i < 3 * 832 + 8 && fs_k.size() < 3; i++) begin
            tick();
            vectors++;
            if (obs_all !== expect_all(k)) begin
                miscompares++;
                $display("FAIL frame_run k=%0d got=%h exp=%h", k, obs_all, expect_all(k));
            end
            if ((prev_ls && a_ls) || (prev_fs && a_fs)) pulse_err++;
            prev_ls = a_ls;
            prev_fs = a_fs;
            if (a_fs) fs_k.push_back(k);
            if (a_ls) last_ls_k = k;
            if (!a_ready && (a_col != 11'd0 || a_row != 11'd0)) gate_err++;
            if (a_ready && (a_col >= 11'd16 || a_row >= 11'd6)) gate_err++;
            if (fs_k.size() >= 1 && fs_k.size() < 3) begin
                if (a_vs == 1'b0) vs_low++;
                if (a_ready) begin
                    rdy_cnt++;
                    if (32'(a_col) > max_col) max_col = 32'(a_col);
                    if (32'(a_row) > max_row) max_row = 32'(a_row);
                    if (!seen_rdy) begin
                        seen_rdy    = 1'b1;
                        first_rdy_k = k;
                        first_col   = a_col;
                        first_row   = a_row;
                    end
                end
            end
            if (seen_rdy && first_rdy_k == k && (k - last_ls_k) != 24) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_delay got=%0d clks after line_start exp=24", k - last_ls_k);
            end
        end
        vectors++;
        if (fs_k.size() != 3) begin
            miscompares++;
            $display("FAIL frame_start_count got=%0d exp=3", fs_k.size());
        end else begin
            vectors++;
            if ((fs_k[1] - fs_k[0]) != 832 || (fs_k[2] - fs_k[1]) != 832) begin
                miscompares++;
                $display("FAIL frame_period got=%0d,%0d exp=832", fs_k[1] - fs_k[0], fs_k[2] - fs_k[1]);
            end
        end
        vectors++;
        if (vs_low != 256) begin
            miscompares++;
            $display("FAIL vsync_width got=%0d exp=256 over two frames", vs_low);
        end
        vectors++;
        if (rdy_cnt != 384 || max_col != 15 || max_row != 5) begin
            miscompares++;
            $display("FAIL active_window got cnt=%0d maxc=%0d maxr=%0d exp 384/15/5", rdy_cnt, max_col, max_row);
        end
        vectors++;
        if (first_col !== 11'd0 || first_row !== 11'd0) begin
            miscompares++;
            $display("FAIL first_active got col=%0d row=%0d exp 0/0", first_col, first_row);
        end
        vectors++;
        if (gate_err != 0 || pulse_err != 0) begin
            miscompares++;
            $display("FAIL gating_pulses got gate=%0d pulse=%0d exp 0/0", gate_err, pulse_err);
        end
    endtask

    task automatic test_mid_frame_reset();
        int unsigned th;
        int unsigned hold;
        bit found;
        th    = $urandom_range(0, 31);
        hold  = $urandom_range(0, 2);
        found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            tick();
            vectors++;
            if (obs_all !== expect_all(k)) begin
                miscompares++;
                $display("FAIL mid_search k=%0d got=%h exp=%h", k, obs_all, expect_all(k));
            end
            if ((k / 2) >= 1 && (k % 2) == 1 && (((k / 2) - 1) % 416) == 7 * 32 + th) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_search_timeout got=none exp=position v7 h%0d", th);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obs_a !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got=%h exp=%h", obs_a, {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        for (int i = 0; i < int'(hold); i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs_all !== expect_all(k)) begin
                miscompares++;
                $display("FAIL mid_restart k=%0d got=%h exp=%h", k, obs_all, expect_all(k));
            end
        end
        vectors++;
        if (a_fs !== 1'b1 || a_fc !== 8'd1) begin
            miscompares++;
            $display("FAIL mid_restart_frame got fs=%b fc=%0d exp fs=1 fc=1", a_fs, a_fc);
        end
    endtask

    task automatic test_frame_wrap();
        logic [7:0]  prev_fc;
        int unsigned last_ls_k, first_gap;
        int          nls, pulse_err;
        bit          saw_wrap, prev_ls;
        prev_fc = b_fc; last_ls_k = 0; first_gap = 0; nls = 0; pulse_err = 0;
        saw_wrap = 1'b0; prev_ls = b_ls;
        for (int i = 0; i < 258 * 112 && !saw_wrap; i++) begin
            tick();
            vectors++;
            if (obs_all !== expect_all(k)) begin
                miscompares++;
                $display("FAIL wrap_run k=%0d got=%h exp=%h", k, obs_all, expect_all(k));
            end
            if (prev_ls && b_ls) pulse_err++;
            prev_ls = b_ls;
            if (b_ls) begin
                nls++;
                if (nls == 2) first_gap = k - last_ls_k;
                last_ls_k = k;
            end
            if (b_fs && prev_fc == 8'd255 && b_fc == 8'd0) saw_wrap = 1'b1;
            prev_fc = b_fc;
        end
        vectors++;
        if (!saw_wrap) begin
            miscompares++;
            $display("FAIL frame_cnt_wrap got fc=%0d exp 255->0 transition", b_fc);
        end
        vectors++;
        if (first_gap != 16 || pulse_err != 0) begin
            miscompares++;
            $display("FAIL div1_line got gap=%0d pulse_err=%0d exp 16/0", first_gap, pulse_err);
        end
    endtask

    initial begin
        k = 0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_mid_frame_reset();
        test_frame_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
